shift_seq_ctrl: RTL and testbench

//  Sequencer for the 6-bit load/shift-left register. On START it issues one

---
 rtl/shift_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Load/shift-left sequencer: one load cycle, then a saturated number of
// shift cycles (with pause and cancel), then a single completion pulse.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic             hold,
    input  logic             abort,
    output logic             en,
    output logic             shift_load,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remain
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    // SHIFT issues a shift this cycle; PAUSE is a held SHIFT with EN low,
    // so EN stays a pure function of registered state.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        PAUSE,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] amt_sat;

    assign amt_sat = (amt > CNT_MAX) ? CNT_MAX : amt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = amt_sat;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    state_d = SHIFT;
                end else begin
                    state_d = FIN;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // The shift was issued this cycle, so the count always
                    // drops; HOLD only decides whether the next cycle pauses.
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1)
                        state_d = FIN;
                    else if (hold)
                        state_d = PAUSE;
                    else
                        state_d = SHIFT;
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!hold) begin
                    state_d = SHIFT;
                end
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        en         = 1'b0;
        shift_load = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        remain     = '0;
        case (state_q)
            LOAD: begin
                en     = 1'b1;
                busy   = 1'b1;
                remain = cnt_q;
            end
            SHIFT: begin
                en         = 1'b1;
                shift_load = 1'b1;
                busy       = 1'b1;
                remain     = cnt_q;
            end
            PAUSE: begin
                shift_load = 1'b1;
                busy       = 1'b1;
                remain     = cnt_q;
            end
            FIN: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus queues expected sequence
// summaries, a monitor checks them on each DONE pulse.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 6;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] amt = '0;
    logic             hold = 1'b0;
    logic             abort = 1'b0;
    logic             en, shift_load, busy, done;
    logic [CNT_W-1:0] remain;

    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] sreg = '0;

    typedef struct {
        int out;
        int en_cycles;
        int busy_cycles;
        int rem0;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done_exp = 0;
    int   n_done_seen = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .amt(amt), .hold(hold),
        .abort(abort), .en(en), .shift_load(shift_load), .busy(busy),
        .done(done), .remain(remain)
    );

    always #5 clk = ~clk;

    // Controlled 6-bit register, not reset, fed by the sequencer outputs.
    always @(posedge clk)
        if (en) sreg <= shift_load ? {sreg[WIDTH-2:0], 1'b0} : din;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int a);
        return (a > WIDTH) ? WIDTH : a;
    endfunction

    // Monitor: accumulates per-sequence activity, compares on DONE.
    int   m_en = 0, m_busy = 0, m_rem0 = -1;
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            m_en = 0; m_busy = 0; m_rem0 = -1;
        end else if (done) begin
            n_done_seen++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("en_cycles", m_en, e.en_cycles);
                chk("busy_cycles", m_busy, e.busy_cycles);
                chk("remain_first", m_rem0, e.rem0);
                chk("reg_out", int'(sreg), e.out);
            end
            chk("done_en_low", int'({en, busy}), 0);
            m_en = 0; m_busy = 0; m_rem0 = -1;
        end else if (busy) begin
            if (m_busy == 0) m_rem0 = int'(remain);
            m_busy++;
            if (en) m_en++;
        end else begin
            m_en = 0; m_busy = 0; m_rem0 = -1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("timeout_idle", 1, 0);
        @(negedge clk);
    endtask

    task automatic push_exp(input int d, input int a, input int h);
        exp_t x;
        int s = sat(a);
        x.out         = (d << s) & ((1 << WIDTH) - 1);
        x.en_cycles   = 1 + s;
        x.busy_cycles = 1 + s + ((s >= 2) ? h : 0);
        x.rem0        = s;
        q.push_back(x);
        n_done_exp++;
    endtask

    // Issue START; hold asserted for h cycles from the first shift cycle,
    // or abort sampled at the end of busy cycle ab_k (0 = LOAD) if ab_k >= 0.
    task automatic run_txn(input int d, input int a, input int h, input int ab_k);
        @(negedge clk);
        din = WIDTH'(d); amt = CNT_W'(a); start = 1'b1;
        if (ab_k < 0) push_exp(d, a, h);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (ab_k >= 0) begin
            repeat (ab_k) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_outputs", int'({en, busy, done, shift_load}), 0);
            chk("abort_remain", int'(remain), 0);
        end else begin
            hold = (h > 0);
            @(posedge clk);
            repeat (h) @(posedge clk);
            @(negedge clk);
            hold = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int d, a, h, k;
        #1;
        chk("reset_outputs", int'({en, shift_load, busy, done}), 0);
        chk("reset_remain", int'(remain), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outputs", int'({en, shift_load, busy, done}), 0);

        // Asynchronous reset mid-shift: AMT=4, after two shifts.
        @(negedge clk);
        din = 6'b000111; amt = 3'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", int'({en, shift_load, busy, done}), 0);
        chk("async_reset_remain", int'(remain), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reg_held_after_reset", int'(sreg), 6'b011100);

        run_txn(6'b000101, 2, 0, -1);     // OUT=010100, 3 busy cycles
        run_txn(6'b101101, 0, 0, -1);     // load only
        run_txn(6'b000111, 3, 2, -1);     // hold 2 cycles
        run_txn(6'b111111, 7, 0, -1);     // saturates to 6 shifts, OUT=0
        run_txn(6'b110011, 7, 0, 6);      // abort with REMAIN=1
        run_txn(6'b010101, 4, 0, 0);      // abort in LOAD

        // START held high: three back-to-back AMT=1 sequences.
        @(negedge clk);
        din = 6'b001011; amt = 3'd1; start = 1'b1;
        repeat (3) push_exp(6'b001011, 1, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            d = int'($urandom_range(0, 63));
            a = int'($urandom_range(0, 7));
            h = int'($urandom_range(0, 3));
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, sat(a))) : -1;
            run_txn(d, a, (k >= 0) ? 0 : h, k);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("done_count", n_done_seen, n_done_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
